// File: rtl/vc32_bus_responder_if.sv
// rtl/vc32_bus_responder_if.sv - vc32 8-bit multiplexed bus between CPU master and responder
interface vc32_bus_responder_if;
    logic [7:0] bus_in;
    logic       latch_hi;
    logic       latch_lo;
    logic       write;
    logic       ind;
    logic [7:0] bus_out;
    logic       interrupt;
    logic       proto_err;

    modport master (
        output bus_in, latch_hi, latch_lo, write, ind,
        input  bus_out, interrupt, proto_err
    );

    modport slave (
        input  bus_in, latch_hi, latch_lo, write, ind,
        output bus_out, interrupt, proto_err
    );
endinterface

// File: rtl/vc32_bus_responder.sv
// rtl/vc32_bus_responder.sv - vc32 bus target: address decode FSM, byte RAM, countdown timer
module vc32_bus_responder #(
    parameter int          MEM_BYTES  = 4096,
    parameter logic [15:0] TIMER_ADDR = 16'hFF00,
    parameter logic [7:0]  FILL       = 8'hFF
) (
    input  logic                 clk,
    input  logic                 r_reset,
    vc32_bus_responder_if.slave  bus
);
    localparam int          AW     = $clog2(MEM_BYTES);
    localparam logic [15:0] T_LO   = TIMER_ADDR;
    localparam logic [15:0] T_HI   = TIMER_ADDR + 16'd1;
    localparam logic [15:0] T_ST   = TIMER_ADDR + 16'd2;
    localparam logic [14:0] T_ST_W = T_ST[15:1];

    typedef enum logic [1:0] {S_IDLE, S_HI, S_VALID} state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [6:0]  addr_lo_q, addr_lo_d;
    logic [15:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic        perr_q, perr_d;

    logic [7:0]  mem [MEM_BYTES];

    logic [1:0]  n_strobe;
    logic        multi;
    logic [15:0] ea;
    logic        ea_valid, ea_in_ram, wr_commit;
    logic        hit_lo, hit_hi, hit_st;
    logic        irq_set;

    // Address decode; latch_lo bypasses addr_lo so the master sees data in its latch_lo cycle
    always_comb begin
        n_strobe  = {1'b0, bus.latch_hi} + {1'b0, bus.latch_lo} + {1'b0, bus.write};
        multi     = (n_strobe > 2'd1);
        ea        = {addr_hi_q, (bus.latch_lo ? bus.bus_in[7:1] : addr_lo_q), bus.ind};
        ea_valid  = ((state_q == S_HI) && bus.latch_lo) || (state_q == S_VALID);
        ea_in_ram = ((ea >> AW) == 16'd0);
        hit_lo    = (ea == T_LO);
        hit_hi    = (ea == T_HI);
        hit_st    = (ea[15:1] == T_ST_W);
        wr_commit = (state_q == S_VALID) && bus.write && !multi;
    end

    always_comb begin
        bus.bus_out = FILL;
        if (ea_valid) begin
            if (hit_lo)         bus.bus_out = count_q[7:0];
            else if (hit_hi)    bus.bus_out = count_q[15:8];
            else if (hit_st)    bus.bus_out = {7'b0, irq_q};
            else if (ea_in_ram) bus.bus_out = mem[ea[AW-1:0]];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        addr_lo_d = addr_lo_q;
        perr_d    = perr_q;
        if (multi) begin
            perr_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.latch_hi) begin
                        state_d   = S_HI;
                        addr_hi_d = bus.bus_in;
                    end else if (bus.latch_lo || bus.write) begin
                        perr_d = 1'b1;
                    end
                end
                S_HI: begin
                    if (bus.latch_hi) begin
                        addr_hi_d = bus.bus_in;
                    end else if (bus.latch_lo) begin
                        state_d   = S_VALID;
                        addr_lo_d = bus.bus_in[7:1];
                    end else if (bus.write) begin
                        perr_d = 1'b1;
                    end
                end
                S_VALID: begin
                    if (bus.latch_hi) begin
                        state_d   = S_HI;
                        addr_hi_d = bus.bus_in;
                    end else if (bus.latch_lo) begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A count byte write replaces the decrement for the whole count, so it can never fire irq
    always_comb begin
        count_d = (count_q != 16'd0) ? (count_q - 16'd1) : count_q;
        irq_set = (count_q == 16'd1);
        if (wr_commit && hit_lo) begin
            count_d = {count_q[15:8], bus.bus_in};
            irq_set = 1'b0;
        end else if (wr_commit && hit_hi) begin
            count_d = {bus.bus_in, count_q[7:0]};
            irq_set = 1'b0;
        end
        irq_d = irq_q;
        if (wr_commit && hit_st) irq_d = 1'b0;
        if (irq_set)             irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state_q   <= S_IDLE;
            addr_hi_q <= 8'h00;
            addr_lo_q <= 7'h00;
            count_q   <= 16'h0000;
            irq_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            addr_lo_q <= addr_lo_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
            perr_q    <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!r_reset && wr_commit && ea_in_ram) begin
            mem[ea[AW-1:0]] <= bus.bus_in;
        end
    end

    assign bus.interrupt = irq_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_vc32_bus_responder.sv
// tb/tb_vc32_bus_responder.sv - self-checking bench for vc32_bus_responder
module tb_vc32_bus_responder;
    logic clk = 1'b0;
    logic r_reset = 1'b1;

    vc32_bus_responder_if bus ();

    vc32_bus_responder dut (
        .clk     (clk),
        .r_reset (r_reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         lh;
        bit         ll;
        bit         wr;
        bit         ind;
        logic [7:0] din;
        bit         chk;
        logic [7:0] eo;
        bit         ep;
        bit         ei;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit lh, bit ll, bit wr, bit ind, logic [7:0] din,
                                bit chk, logic [7:0] eo, bit ep, bit ei);
        vec_t v;
        v.rst = rst; v.lh = lh; v.ll = ll; v.wr = wr; v.ind = ind; v.din = din;
        v.chk = chk; v.eo = eo; v.ep = ep; v.ei = ei;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [7:0] exp_b;
        r_reset      = v.rst;
        bus.latch_hi = v.lh;
        bus.latch_lo = v.ll;
        bus.write    = v.wr;
        bus.ind      = v.ind;
        bus.bus_in   = v.din;
        if (v.chk) sb_q.push_back(v.eo);
        @(negedge clk);
        if (v.chk) begin
            exp_b = sb_q.pop_front();
            n_checks++;
            if (bus.bus_out !== exp_b) begin
                n_errors++;
                $display("FAIL %s bus_out got %02h exp %02h", name, bus.bus_out, exp_b);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.proto_err !== v.ep) begin
            n_errors++;
            $display("FAIL %s proto_err got %b exp %b", name, bus.proto_err, v.ep);
        end
        n_checks++;
        if (bus.interrupt !== v.ei) begin
            n_errors++;
            $display("FAIL %s interrupt got %b exp %b", name, bus.interrupt, v.ei);
        end
    endtask

    initial begin
        bus.latch_hi = 1'b0;
        bus.latch_lo = 1'b0;
        bus.write    = 1'b0;
        bus.ind      = 1'b0;
        bus.bus_in   = 8'h00;

        // reset and reset state
        tbl.push_back(mk(1,0,0,0,0,8'h00,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,0,8'h00,0,8'h00,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'hFF,0,0));
        // 16-bit store 0124 <- BEEF, then 16-bit read
        tbl.push_back(mk(0,1,0,0,0,8'h01,1,8'hFF,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h24,0,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,0,8'hEF,0,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,1,8'hBE,0,8'h00,0,0));
        tbl.push_back(mk(0,1,0,0,0,8'h01,1,8'hEF,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'hFF,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h24,1,8'hEF,0,0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,1,8'hBE,0,0));
        // byte write 0125 <- 5A with write-after-read
        tbl.push_back(mk(0,1,0,0,0,8'h01,1,8'hEF,0,0));
        tbl.push_back(mk(0,0,1,0,1,8'h24,1,8'hBE,0,0));
        tbl.push_back(mk(0,0,0,1,1,8'h5A,1,8'hBE,0,0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,1,8'h5A,0,0));
        tbl.push_back(mk(0,1,0,0,0,8'h01,1,8'hEF,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h24,1,8'hEF,0,0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,1,8'h5A,0,0));
        tbl.push_back(mk(0,1,0,0,1,8'h01,1,8'h5A,0,0));
        tbl.push_back(mk(0,0,1,0,1,8'h24,1,8'h5A,0,0));
        // 0000 <- 11, then 2000 out of RAM: reads FILL, write must not alias onto 0000
        tbl.push_back(mk(0,1,0,0,0,8'h00,1,8'hEF,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00,0,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,0,8'h11,0,8'h00,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'h11,0,0));
        tbl.push_back(mk(0,1,0,0,0,8'h20,1,8'h11,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00,1,8'hFF,0,0));
        tbl.push_back(mk(0,0,0,1,0,8'h77,1,8'hFF,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'hFF,0,0));
        tbl.push_back(mk(0,1,0,0,0,8'h00,1,8'hFF,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00,1,8'h11,0,0));
        // timer: load 0003, irq three clocks after the hi byte write, read and clear status
        tbl.push_back(mk(0,1,0,0,0,8'hFF,1,8'h11,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00,1,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,0,8'h03,1,8'h00,0,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00,1,8'h00,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'h03,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'h02,0,0));
        tbl.push_back(mk(0,0,0,0,1,8'h00,1,8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'h00,0,1));
        tbl.push_back(mk(0,1,0,0,0,8'hFF,1,8'h00,0,1));
        tbl.push_back(mk(0,0,1,0,0,8'h02,1,8'h01,0,1));
        tbl.push_back(mk(0,0,0,0,1,8'h00,1,8'h01,0,1));
        tbl.push_back(mk(0,0,0,1,0,8'h00,1,8'h01,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,8'h00,0,0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // latch_lo with no latch_hi after reset: sticky error
        apply(mk(1,0,0,0,0,8'h00,0,8'h00,0,0), "a_rst");
        apply(mk(0,0,1,0,0,8'h24,1,8'hFF,1,0), "a_lo_idle");
        apply(mk(0,0,0,0,0,8'h00,1,8'hFF,1,0), "a_sticky");

        // latch_hi + write together: error, strobes ignored, RAM and address unchanged
        apply(mk(1,0,0,0,0,8'h00,0,8'h00,0,0), "b_rst");
        apply(mk(0,1,0,0,0,8'h00,1,8'hFF,0,0), "b_hi");
        apply(mk(0,0,1,0,0,8'h00,1,8'h11,0,0), "b_lo");
        apply(mk(0,1,0,1,0,8'h99,1,8'h11,1,0), "b_hi_wr");
        apply(mk(0,0,0,0,0,8'h00,1,8'h11,1,0), "b_after");

        // write in HI is dropped and flagged
        apply(mk(1,0,0,0,0,8'h00,0,8'h00,0,0), "c_rst");
        apply(mk(0,1,0,0,0,8'h01,1,8'hFF,0,0), "c_hi");
        apply(mk(0,0,0,1,0,8'h33,1,8'hFF,1,0), "c_wr_hi");
        apply(mk(0,0,1,0,0,8'h24,1,8'hEF,1,0), "c_lo");
        apply(mk(0,0,1,0,0,8'h24,1,8'hEF,1,0), "c_lo_valid");

        // reset between latch_hi and latch_lo
        apply(mk(1,0,0,0,0,8'h00,0,8'h00,0,0), "d_rst");
        apply(mk(0,1,0,0,0,8'h01,1,8'hFF,0,0), "d_hi");
        apply(mk(1,0,0,0,0,8'h00,0,8'h00,0,0), "d_rst_mid");
        apply(mk(0,0,1,0,0,8'h24,1,8'hFF,1,0), "d_lo_idle");
        apply(mk(0,1,0,0,0,8'h01,1,8'hFF,1,0), "d_hi2");
        apply(mk(0,0,1,0,0,8'h24,1,8'hEF,1,0), "d_readback");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
